// File: rtl/fifo_wr_ctrl_if.sv
// Producer-facing bundle of the async FIFO write-side controller.
// master = producer/read-side glue, slave = fifo_wr_ctrl.
interface fifo_wr_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W:0]   wptr_gray;
    logic [ADDR_W:0]   rptr_gray_sync;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              flush_req;
    logic              flush_done;
    logic              err_ptr;

    modport master (
        output wr_valid,
        output rptr_gray_sync,
        output flush_req,
        input  wr_ready,
        input  mem_we,
        input  mem_waddr,
        input  wptr_gray,
        input  full,
        input  almost_full,
        input  wr_level,
        input  flush_done,
        input  err_ptr
    );

    modport slave (
        input  wr_valid,
        input  rptr_gray_sync,
        input  flush_req,
        output wr_ready,
        output mem_we,
        output mem_waddr,
        output wptr_gray,
        output full,
        output almost_full,
        output wr_level,
        output flush_done,
        output err_ptr
    );
endinterface

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter: bit i is the XOR of all gray bits at or above i.
module gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: write pointers, occupancy flags, backpressure
// and a flush/drain handshake, all in the write clock domain.
module fifo_wr_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AFULL_TH = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_wr_ctrl_if.slave bus
);
    localparam int unsigned PW    = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_TH);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr_gray;
    logic [PW-1:0] r_level;
    logic          r_full;
    logic          r_afull;
    logic          r_err;

    logic          w_ready;
    logic          w_push;
    logic          w_flush_done;
    logic [PW-1:0] w_wbin_nxt;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_lvl_nxt;

    gray2bin #(
        .W (PW)
    ) u_rptr_g2b (
        .i_gray (bus.rptr_gray_sync),
        .o_bin  (w_rbin)
    );

    assign w_push     = bus.wr_valid & w_ready;
    assign w_wbin_nxt = r_wbin + PW'(w_push);
    // Modular subtraction: a pop and a push in the same cycle both land here.
    assign w_lvl_nxt  = w_wbin_nxt - w_rbin;

    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_flush_done = 1'b0;
        unique case (r_state)
            StRun: begin
                w_ready = ~r_full;
                if (bus.flush_req) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (r_level == '0) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_flush_done = 1'b1;
                w_state_nxt  = StRun;
            end
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_wbin      <= '0;
            r_wptr_gray <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wbin      <= w_wbin_nxt;
            r_wptr_gray <= w_wbin_nxt ^ (w_wbin_nxt >> 1);
            r_level     <= w_lvl_nxt;
            // An impossible level (> DEPTH) also reads as full so pushes stay blocked.
            r_full      <= (w_lvl_nxt >= DEPTH_P);
            r_afull     <= (w_lvl_nxt >= AFULL_P);
            if (w_lvl_nxt > DEPTH_P) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.wr_ready    = w_ready;
    assign bus.mem_we      = w_push;
    assign bus.mem_waddr   = r_wbin[ADDR_W-1:0];
    assign bus.wptr_gray   = r_wptr_gray;
    assign bus.full        = r_full;
    assign bus.almost_full = r_afull;
    assign bus.wr_level    = r_level;
    assign bus.flush_done  = w_flush_done;
    assign bus.err_ptr     = r_err;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed plus randomized bench for fifo_wr_ctrl (ADDR_W=2, DEPTH=4, AFULL_TH=3)
// against an occupancy-arithmetic reference model.
module tb_fifo_wr_ctrl;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFT   = 3;
    localparam int unsigned PMOD  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_ctrl_if #(.ADDR_W(AW)) bus ();

    fifo_wr_ctrl #(
        .ADDR_W   (AW),
        .AFULL_TH (AFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: total pushes mod 8, occupancy, sticky error, flush phase.
    int m_wbin;
    int m_lvl;
    int m_phase;  // 0 running, 1 draining, 2 done
    bit m_full;
    bit m_af;
    bit m_err;
    int m_rbin;   // stimulus: read pointer in binary
    int hist1, hist2;

    function automatic int ref_bin(input logic [2:0] g);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            c = 3'(i ^ (i >> 1));
            if (c == g) return i;
        end
        return 0;
    endfunction

    function automatic logic [2:0] to_gray(input int b);
        return 3'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wbin  = 0;
        m_lvl   = 0;
        m_phase = 0;
        m_full  = 0;
        m_af    = 0;
        m_err   = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_wptr_gray", 32'(bus.wptr_gray), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_almost_full", 32'(bus.almost_full), 0);
        chk("rst_wr_level", 32'(bus.wr_level), 0);
        chk("rst_flush_done", 32'(bus.flush_done), 0);
        chk("rst_err_ptr", 32'(bus.err_ptr), 0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 1);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
    endtask

    // Asynchronous reset: outputs are checked before any clock edge.
    task automatic do_reset();
        bus.wr_valid       = 1'b0;
        bus.flush_req      = 1'b0;
        bus.rptr_gray_sync = '0;
        m_rbin = 0;
        hist1  = 0;
        hist2  = 0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        bit         ready_m;
        bit         push_m;
        int         rb;
        logic [2:0] prev_gray;
        #2;
        ready_m = (m_phase == 0) && !m_full;
        push_m  = bus.wr_valid && ready_m;
        chk("wr_ready", 32'(bus.wr_ready), 32'(ready_m));
        chk("mem_we", 32'(bus.mem_we), 32'(push_m));
        if (push_m) chk("mem_waddr", 32'(bus.mem_waddr), 32'(m_wbin % 4));
        case (m_phase)
            0: if (bus.flush_req) m_phase = 1;
            1: if (m_lvl == 0) m_phase = 2;
            default: m_phase = 0;
        endcase
        m_wbin = (m_wbin + int'(push_m)) % PMOD;
        rb     = ref_bin(bus.rptr_gray_sync);
        m_lvl  = (m_wbin - rb + PMOD) % PMOD;
        m_full = (m_lvl >= DEPTH);
        m_af   = (m_lvl >= AFT);
        if (m_lvl > DEPTH) m_err = 1;
        prev_gray = bus.wptr_gray;
        @(posedge clk);
        #1;
        chk("wptr_gray", 32'(bus.wptr_gray), 32'(to_gray(m_wbin)));
        chk("gray_step", 32'($countones(prev_gray ^ bus.wptr_gray) <= 1), 1);
        chk("wr_level", 32'(bus.wr_level), 32'(m_lvl));
        chk("full", 32'(bus.full), 32'(m_full));
        chk("almost_full", 32'(bus.almost_full), 32'(m_af));
        chk("err_ptr", 32'(bus.err_ptr), 32'(m_err));
        chk("flush_done", 32'(bus.flush_done), 32'(m_phase == 2));
    endtask

    initial begin
        // Fill from empty until full.
        do_reset();
        bus.wr_valid = 1'b1;
        repeat (6) tick();

        // One read pointer step frees one slot.
        bus.rptr_gray_sync = to_gray(1);
        m_rbin = 1;
        repeat (3) tick();

        // Random traffic with the read pointer lagging 2 cycles; wraps and random flushes.
        hist1 = m_wbin;
        hist2 = m_wbin;
        for (int c = 0; c < 80; c++) begin
            bus.wr_valid  = 1'($urandom_range(0, 1));
            bus.flush_req = ($urandom_range(0, 15) == 0);
            if (m_rbin != hist2 && $urandom_range(0, 1) == 1) m_rbin = (m_rbin + 1) % PMOD;
            bus.rptr_gray_sync = to_gray(m_rbin);
            tick();
            hist2 = hist1;
            hist1 = m_wbin;
        end
        bus.flush_req = 1'b0;
        chk("no_err_after_wrap", 32'(bus.err_ptr), 0);

        // Flush with a push in the request cycle, then drain.
        do_reset();
        bus.wr_valid = 1'b1;
        repeat (2) tick();
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        tick();
        bus.wr_valid = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            bus.rptr_gray_sync = to_gray(r);
            tick();
        end
        repeat (4) tick();

        // Flush while already empty.
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        repeat (4) tick();

        // Corrupt read pointer sequence.
        do_reset();
        bus.rptr_gray_sync = 3'b101;
        tick();
        bus.rptr_gray_sync = 3'b111;
        tick();
        bus.rptr_gray_sync = 3'b100;
        tick();
        bus.rptr_gray_sync = 3'b010;
        tick();
        bus.wr_valid = 1'b1;
        repeat (2) tick();
        bus.rptr_gray_sync = 3'b000;
        repeat (2) tick();
        chk("err_sticky", 32'(bus.err_ptr), 1);

        // Reset in the middle of a drain.
        do_reset();
        bus.wr_valid = 1'b1;
        repeat (2) tick();
        bus.wr_valid  = 1'b0;
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        tick();
        do_reset();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
